// File: rtl/audio_pkg.sv
// Shared audio definitions: default word width, receiver FSM states and
// the bit-counter width rule used by the I2S receiver.
package audio_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    sIdle,
    sLeft,
    sRight
  } state_t;

  // The counter must reach WIDTH itself so it can saturate there.
  function automatic int bitcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/i2s_pin_sync.sv
// Synchronizer for one asynchronous I2S pin, plus a history flop that
// yields a single-cycle rising-edge strobe on the synchronized level.
module i2s_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic MCLK,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments move the value one stage per clock.
      sync_q[0] <= pin;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S stereo receiver: synchronizes the pins, deserializes left/right words
// and presents each complete frame through a valid/ready holding stage.
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic             onOff,
  input  logic             SCLK,
  input  logic             LRCLK,
  input  logic             SD,
  output logic [WIDTH-1:0] left_sample,
  output logic [WIDTH-1:0] right_sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  localparam int CW = bitcnt_w(WIDTH);

  logic bit_stb, ws, sd;
  logic lr_rise_unused, sd_rise_unused;

  i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .MCLK(MCLK), .reset(reset), .pin(SCLK), .level(), .rise(bit_stb)
  );
  i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_lrclk (
    .MCLK(MCLK), .reset(reset), .pin(LRCLK), .level(ws), .rise(lr_rise_unused)
  );
  i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sd (
    .MCLK(MCLK), .reset(reset), .pin(SD), .level(sd), .rise(sd_rise_unused)
  );

  state_t           state;
  logic [CW-1:0]    bitcnt, cnt_next;
  logic [WIDTH-1:0] shreg, sh_next, word;
  logic [WIDTH-1:0] left_hold, right_word;
  logic             ws_d, emit;

  // Shift a word of n bits (held in the LSBs) up to the MSB end.
  function automatic logic [WIDTH-1:0] left_justify(input logic [WIDTH-1:0] v,
                                                    input logic [CW-1:0]    n);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < WIDTH; i++)
      if (CW'(i) >= n) r = {r[WIDTH-2:0], 1'b0};
    return r;
  endfunction

  always_comb begin
    // NOTE: defaults first, so every path assigns and no latch is inferred.
    sh_next  = shreg;
    cnt_next = bitcnt;
    if (bitcnt < CW'(WIDTH)) begin
      sh_next  = {shreg[WIDTH-2:0], sd};
      cnt_next = bitcnt + CW'(1);
    end
    word = left_justify(sh_next, cnt_next);
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state      <= sIdle;
      bitcnt     <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      right_word <= '0;
      ws_d       <= 1'b0;
      emit       <= 1'b0;
    end else begin
      emit <= 1'b0;
      if (bit_stb) ws_d <= ws;
      if (!onOff) begin
        state     <= sIdle;
        bitcnt    <= '0;
        shreg     <= '0;
        left_hold <= '0;
      end else if (bit_stb) begin
        case (state)
          sIdle: begin
            // Lock on at the right-to-left boundary only.
            if (ws_d && !ws) begin
              bitcnt <= '0;
              shreg  <= '0;
              state  <= sLeft;
            end
          end
          sLeft, sRight: begin
            if (ws == ws_d) begin
              shreg  <= sh_next;
              bitcnt <= cnt_next;
            end else begin
              // Word-select already flipped: this strobe carries the last bit.
              bitcnt <= '0;
              shreg  <= '0;
              if (state == sLeft) begin
                left_hold <= word;
                state     <= sRight;
              end else begin
                right_word <= word;
                emit       <= 1'b1;
                state      <= sLeft;
              end
            end
          end
          default: state <= sIdle;
        endcase
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (!onOff) begin
      sample_valid <= 1'b0;
    end else if (emit) begin
      if (!sample_valid || sample_ready) begin
        left_sample  <= left_hold;
        right_sample <= right_word;
        sample_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: table-driven frames, corner-case
// sequences and randomized frames against a word-level reference model.
module tb_i2s_receiver;

  localparam int W    = 16;
  localparam int SYNC = 2;

  logic          MCLK = 1'b0;
  logic          reset, onOff, SCLK, LRCLK, SD, sample_ready;
  logic [W-1:0]  left_sample, right_sample;
  logic          sample_valid, overrun;

  i2s_receiver #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .MCLK(MCLK), .reset(reset), .onOff(onOff), .SCLK(SCLK), .LRCLK(LRCLK),
    .SD(SD), .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic ch;
    logic b;
  } slot_t;

  typedef struct {
    int          nl;
    logic [31:0] l;
    int          nr;
    logic [31:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  slot_t       slot_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  vec_t        tbl[5];
  int          checks = 0;
  int          errors = 0;

  // Every accepted frame, packed as {left, right}.
  always @(negedge MCLK)
    if (!reset && sample_valid && sample_ready) got_q.push_back({left_sample, right_sample});

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  task automatic add_word(input logic ch, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) slot_q.push_back('{ch, val[i]});
  endtask

  // Word select for a slot is the channel of the following slot (one-bit delay).
  task automatic play_range(input int lo, input int hi, input int meas);
    int lat;
    for (int i = lo; i <= hi; i++) begin
      LRCLK = (i + 1 < slot_q.size()) ? slot_q[i+1].ch : slot_q[i].ch;
      SD    = slot_q[i].b;
      tick(4);
      SCLK = 1'b1;
      lat  = -1;
      for (int j = 1; j <= 4; j++) begin
        tick(1);
        if (i == meas && lat < 0 && sample_valid) lat = j;
      end
      if (i == meas) check("latency", lat, SYNC + 2);
      SCLK = 1'b0;
    end
  endtask

  task automatic play_all(input int meas);
    play_range(0, slot_q.size() - 1, meas);
  endtask

  function automatic logic [15:0] exp_word(input logic [31:0] v, input int n);
    logic [63:0] m;
    m = {32'b0, v} & ((64'd1 << n) - 64'd1);
    if (n >= 16) m = m >> (n - 16);
    else         m = m << (16 - n);
    return m[15:0];
  endfunction

  task automatic compare_frames(input string nm);
    check({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({nm, "_left"},  got_q[i][31:16], exp_q[i][31:16]);
      check({nm, "_right"}, got_q[i][15:0],  exp_q[i][15:0]);
    end
  endtask

  initial begin
    int meas, i1, i2l, i3r;
    logic [31:0] l, r;
    int nl, nr;

    tbl[0] = '{16, 32'hA5C3,   16, 32'h1234,    16'hA5C3, 16'h1234};
    tbl[1] = '{24, 32'h89ABCD, 24, 32'h123456,  16'h89AB, 16'h1234};
    tbl[2] = '{12, 32'hFFF,    12, 32'h801,     16'hFFF0, 16'h8010};
    tbl[3] = '{16, 32'hFFFF,   16, 32'h0,       16'hFFFF, 16'h0000};
    tbl[4] = '{1,  32'h1,      17, 32'h1FFFF,   16'h8000, 16'hFFFF};

    reset = 1'b1; onOff = 1'b1; SCLK = 1'b0; LRCLK = 1'b0; SD = 1'b0;
    sample_ready = 1'b1;
    tick(3);
    check("rst_left",    left_sample,  16'h0);
    check("rst_right",   right_sample, 16'h0);
    check("rst_valid",   sample_valid, 1'b0);
    check("rst_overrun", overrun,      1'b0);
    reset = 1'b0;

    // Table of frames at SCLK = MCLK/8, consumer always ready.
    slot_q.delete(); got_q.delete(); exp_q.delete();
    add_word(1'b1, 32'h5, 3);
    meas = -1;
    for (int k = 0; k < 5; k++) begin
      add_word(1'b0, tbl[k].l, tbl[k].nl);
      add_word(1'b1, tbl[k].r, tbl[k].nr);
      if (k == 0) meas = slot_q.size() - 1;
      exp_q.push_back({tbl[k].el, tbl[k].er});
    end
    add_word(1'b0, 32'h0, 2);
    play_all(meas);
    tick(8);
    compare_frames("table");
    check("table_overrun", overrun, 1'b0);

    // Consumer stalled across two frames.
    do_reset();
    sample_ready = 1'b0;
    slot_q.delete(); got_q.delete();
    add_word(1'b1, 32'h3, 3);
    add_word(1'b0, 32'h1111, 16);
    add_word(1'b1, 32'h2222, 16);
    i1 = slot_q.size() - 1;
    add_word(1'b0, 32'h3333, 16);
    add_word(1'b1, 32'h4444, 16);
    add_word(1'b0, 32'h0, 2);
    play_range(0, i1, -1);
    check("stall_f1_valid",   sample_valid, 1'b1);
    check("stall_f1_left",    left_sample,  16'h1111);
    check("stall_f1_right",   right_sample, 16'h2222);
    check("stall_f1_overrun", overrun,      1'b0);
    play_range(i1 + 1, slot_q.size() - 1, -1);
    tick(8);
    check("stall_f2_left",    left_sample,  16'h1111);
    check("stall_f2_right",   right_sample, 16'h2222);
    check("stall_f2_valid",   sample_valid, 1'b1);
    check("stall_f2_overrun", overrun,      1'b1);
    sample_ready = 1'b1;
    tick(1);
    check("accept_valid",   sample_valid, 1'b0);
    check("accept_overrun", overrun,      1'b1);
    check("accept_count",   got_q.size(), 1);

    // Reset released in the middle of a right word.
    slot_q.delete(); got_q.delete(); exp_q.delete();
    reset = 1'b1;
    add_word(1'b1, 32'hBEEF, 16);
    add_word(1'b0, 32'h0F0F, 16);
    add_word(1'b1, 32'h7E57, 16);
    add_word(1'b0, 32'h0, 2);
    play_range(0, 5, -1);
    reset = 1'b0;
    play_range(6, slot_q.size() - 1, -1);
    tick(8);
    exp_q.push_back({16'h0F0F, 16'h7E57});
    compare_frames("midreset");

    // Receiver disabled mid left word, re-enabled two frames later.
    do_reset();
    sample_ready = 1'b0;
    slot_q.delete(); got_q.delete(); exp_q.delete();
    add_word(1'b1, 32'h1, 3);
    add_word(1'b0, 32'hC001, 16);
    add_word(1'b1, 32'h0D15, 16);
    i2l = slot_q.size();
    add_word(1'b0, 32'h5A5A, 16);
    add_word(1'b1, 32'h6B6B, 16);
    add_word(1'b0, 32'h7C7C, 16);
    i3r = slot_q.size();
    add_word(1'b1, 32'h8D8D, 16);
    add_word(1'b0, 32'h1357, 16);
    add_word(1'b1, 32'h2468, 16);
    add_word(1'b0, 32'h0, 2);
    play_range(0, i2l + 5, -1);
    check("off_pre_valid", sample_valid, 1'b1);
    check("off_pre_left",  left_sample,  16'hC001);
    check("off_pre_right", right_sample, 16'h0D15);
    onOff = 1'b0;
    tick(1);
    check("off_valid", sample_valid, 1'b0);
    sample_ready = 1'b1;
    play_range(i2l + 6, i3r + 5, -1);
    onOff = 1'b1;
    play_range(i3r + 6, slot_q.size() - 1, -1);
    tick(8);
    exp_q.push_back({16'h1357, 16'h2468});
    compare_frames("onoff");
    check("onoff_overrun", overrun, 1'b0);

    // Randomized word lengths and contents.
    do_reset();
    sample_ready = 1'b1;
    slot_q.delete(); got_q.delete(); exp_q.delete();
    add_word(1'b1, 32'h2, 2);
    for (int f = 0; f < 8; f++) begin
      nl = $urandom_range(1, 28);
      nr = $urandom_range(1, 28);
      l  = $urandom;
      r  = $urandom;
      add_word(1'b0, l, nl);
      add_word(1'b1, r, nr);
      exp_q.push_back({exp_word(l, nl), exp_word(r, nr)});
    end
    add_word(1'b0, 32'h0, 2);
    play_all(-1);
    tick(8);
    compare_frames("random");
    check("random_overrun", overrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
